// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data memory.
// The pipeline wins by default; a starved debug/loader port is eventually forced through.
module dmem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p_req,
   input  logic [ADDR_WIDTH-1:0] p_addr,
   input  logic [DATA_WIDTH-1:0] p_wdata,
   input  logic [3:0]            p_wen,
   output logic                  p_gnt,
   output logic                  p_stall,
   output logic                  p_rvalid,
   output logic [DATA_WIDTH-1:0] p_rdata,
   input  logic                  d_req,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_wen,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [3:0]            m_wen,
   input  logic [DATA_WIDTH-1:0] m_rdata
);

   typedef enum logic [1:0] {OWN_NONE, OWN_P, OWN_D} owner_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [3:0]            wen;
   } mreq_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]            starve_cnt, starve_nxt;
   owner_t                rd_owner, owner_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  forced;
   mreq_t                 sel;

   always_comb begin
      forced     = d_req && (starve_cnt == LIMIT);
      d_gnt      = !rst && d_req && (forced || !p_req);
      p_gnt      = !rst && p_req && !d_gnt;
      p_stall    = !rst && p_req && !p_gnt;
      starve_nxt = 4'd0;
      if (d_req && !d_gnt)
         starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
      // Idle bus keeps the last address/data so the memory pins do not toggle.
      sel = '{addr: addr_q, wdata: wdata_q, wen: 4'b0000};
      owner_nxt = OWN_NONE;
      if (p_gnt) begin
         sel = '{addr: p_addr, wdata: p_wdata, wen: p_wen};
         if (p_wen == 4'b0000) owner_nxt = OWN_P;
      end else if (d_gnt) begin
         sel = '{addr: d_addr, wdata: d_wdata, wen: d_wen};
         if (d_wen == 4'b0000) owner_nxt = OWN_D;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
         rd_owner   <= OWN_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         rd_owner   <= owner_nxt;
         addr_q     <= sel.addr;
         wdata_q    <= sel.wdata;
      end
   end

   assign m_addr   = sel.addr;
   assign m_wdata  = sel.wdata;
   assign m_wen    = sel.wen;
   assign p_rvalid = (rd_owner == OWN_P);
   assign d_rvalid = (rd_owner == OWN_D);
   assign p_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a grant/mux vector table plus multi-cycle sequences
// for read latency, starvation forcing, write gating, interleaved reads and reset.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_req, d_req;
   logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
   logic [3:0]  p_wen, d_wen;
   logic        p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid;
   logic [31:0] p_rdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wen;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .p_req(p_req), .p_addr(p_addr), .p_wdata(p_wdata), .p_wen(p_wen),
      .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, 256 words, pre-filled with a recognisable pattern.
   logic [31:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (m_wen[b]) mem[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      m_rdata <= mem[m_addr[9:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic pr, input logic [31:0] pa, input logic [31:0] pd, input logic [3:0] pw,
                      input logic dr, input logic [31:0] da, input logic [31:0] dd, input logic [3:0] dw);
      p_req = pr; p_addr = pa; p_wdata = pd; p_wen = pw;
      d_req = dr; d_addr = da; d_wdata = dd; d_wen = dw;
   endtask

   task automatic next_cyc;
      @(posedge clk); #1;
   endtask

   task automatic idle;
      drv(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   typedef struct {
      logic        pr;
      logic [3:0]  pw;
      logic        dr;
      logic [3:0]  dw;
      logic        e_pg, e_dg, e_st;
      logic [3:0]  e_wen;
      logic [31:0] e_addr;
   } vec_t;

   vec_t tbl [11];

   initial begin
      // grant table: p side at 0x200, d side at 0x300; starve count carries across rows
      tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[1]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h200};
      tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'hF, 32'h300};
      tbl[3]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h300};
      tbl[4]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[5]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[6]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[7]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[8]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[9]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200};
      tbl[10] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h200};

      // reset with both requesting: nothing granted, bus quiet
      rst = 1'b1;
      drv(1'b1, 32'h104, 32'h1, 4'hF, 1'b1, 32'h108, 32'h2, 4'hF);
      repeat (2) @(negedge clk);
      chk("rst_p_gnt", {31'd0, p_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_p_stall", {31'd0, p_stall}, 32'd0);
      chk("rst_m_wen", {28'd0, m_wen}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd0);
      next_cyc; rst = 1'b0; idle;

      for (int i = 0; i < 11; i++) begin
         next_cyc;
         drv(tbl[i].pr, 32'h200, 32'h1234_5678, tbl[i].pw, tbl[i].dr, 32'h300, 32'hCAFE_F00D, tbl[i].dw);
         @(negedge clk);
         chk($sformatf("v%0d_p_gnt", i), {31'd0, p_gnt}, {31'd0, tbl[i].e_pg});
         chk($sformatf("v%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, tbl[i].e_dg});
         chk($sformatf("v%0d_stall", i), {31'd0, p_stall}, {31'd0, tbl[i].e_st});
         chk($sformatf("v%0d_m_wen", i), {28'd0, m_wen}, {28'd0, tbl[i].e_wen});
         chk($sformatf("v%0d_m_addr", i), m_addr, tbl[i].e_addr);
      end

      // single pipeline read of 0x100, data one cycle later
      next_cyc; drv(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("rd_p_gnt", {31'd0, p_gnt}, 32'd1);
      chk("rd_m_wen", {28'd0, m_wen}, 32'd0);
      next_cyc; idle;
      @(negedge clk);
      chk("rd_p_rvalid", {31'd0, p_rvalid}, 32'd1);
      chk("rd_p_rdata", p_rdata, 32'hA500_0040);
      chk("rd_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      next_cyc;
      @(negedge clk);
      chk("rd_rvalid_one", {31'd0, p_rvalid}, 32'd0);

      // starvation: pipeline wins 4 cycles, debug forced on the 5th, then pipeline again
      for (int c = 0; c < 6; c++) begin
         next_cyc; drv(1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h104, 32'h0, 4'h0);
         @(negedge clk);
         chk($sformatf("st%0d_p_gnt", c), {31'd0, p_gnt}, (c == 4) ? 32'd0 : 32'd1);
         chk($sformatf("st%0d_d_gnt", c), {31'd0, d_gnt}, (c == 4) ? 32'd1 : 32'd0);
         chk($sformatf("st%0d_stall", c), {31'd0, p_stall}, (c == 4) ? 32'd1 : 32'd0);
         if (c == 5) begin
            chk("st5_cnt", {28'd0, dut.starve_cnt}, 32'd0);
            chk("st5_d_rvalid", {31'd0, d_rvalid}, 32'd1);
            chk("st5_d_rdata", d_rdata, 32'hA500_0041);
         end
      end
      next_cyc; idle;

      // debug write, no rvalid, then pipeline readback
      next_cyc; drv(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      chk("dw_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("dw_m_wen", {28'd0, m_wen}, 32'hF);
      chk("dw_m_wdata", m_wdata, 32'hDEAD_BEEF);
      next_cyc; drv(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("dw_no_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd0);
      next_cyc; idle;
      @(negedge clk);
      chk("dw_readback_v", {31'd0, p_rvalid}, 32'd1);
      chk("dw_readback", p_rdata, 32'hDEAD_BEEF);

      // pipeline write blocked by a forced debug read
      for (int c = 0; c < 4; c++) begin
         next_cyc; drv(1'b1, 32'h80, 32'h0, 4'h0, 1'b1, 32'h40, 32'h0, 4'h0);
      end
      next_cyc; drv(1'b1, 32'h80, 32'h1111_2222, 4'h3, 1'b1, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      chk("gw_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("gw_m_wen", {28'd0, m_wen}, 32'd0);
      chk("gw_stall", {31'd0, p_stall}, 32'd1);
      next_cyc; idle;
      @(negedge clk);
      chk("gw_d_rdata", d_rdata, 32'hDEAD_BEEF);

      // interleaved reads P, D, P
      next_cyc; drv(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      next_cyc; drv(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      chk("il1_p_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd2);
      chk("il1_p_rdata", p_rdata, 32'hA500_0040);
      next_cyc; drv(1'b1, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("il2_d_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd1);
      chk("il2_d_rdata", d_rdata, 32'hDEAD_BEEF);
      next_cyc; idle;
      @(negedge clk);
      chk("il3_p_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd2);
      chk("il3_p_rdata", p_rdata, 32'hA500_0020);

      // reset while a read is in flight and debug is building up starvation
      next_cyc; drv(1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h40, 32'h0, 4'h0);
      next_cyc; rst = 1'b1;
      @(negedge clk);
      chk("mr_rst_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd0);
      chk("mr_rst_p_gnt", {31'd0, p_gnt}, 32'd0);
      next_cyc; rst = 1'b0; idle;
      @(negedge clk);
      chk("mr_post_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd0);
      chk("mr_post_cnt", {28'd0, dut.starve_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied debug-request cycles before forced debug grant; range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports p_req/p_addr/p_wdata/p_wen  input  1/ADDR_WIDTH/DATA_WIDTH/4  pipeline MEM-stage request, address, store data, byte write enables.
REQ-007 SHALL have ports p_gnt/p_stall/p_rvalid/p_rdata  output  1/1/1/DATA_WIDTH  pipeline grant, stall request, read-data valid, read data.
REQ-008 SHALL have ports d_req/d_addr/d_wdata/d_wen  input  1/ADDR_WIDTH/DATA_WIDTH/4  debug/loader request, same meaning as pipeline side.
REQ-009 SHALL have ports d_gnt/d_rvalid/d_rdata  output  1/1/DATA_WIDTH  debug grant, read-data valid, read data.
REQ-010 SHALL have ports m_addr/m_wdata/m_wen  output  ADDR_WIDTH/DATA_WIDTH/4  to single-port synchronous data memory.
REQ-011 SHALL have port m_rdata  input  DATA_WIDTH  memory read data, valid one cycle after address.

Function
REQ-012 SHALL grant at most one requester per cycle; p_gnt and d_gnt combinational, never both 1.
REQ-013 SHALL default to pipeline priority: p_req=1 and no forced debug grant -> p_gnt=1, d_gnt=0.
REQ-014 SHALL keep 4-bit starve_cnt: increments each cycle d_req=1 and d_gnt=0, saturates at STARVE_LIMIT, clears on d_gnt=1 or d_req=0.
REQ-015 SHALL force d_gnt=1, p_gnt=0 when d_req=1 and starve_cnt==STARVE_LIMIT, regardless of p_req.
REQ-016 SHALL assert p_stall=1 exactly in cycles where p_req=1 and p_gnt=0; else 0.
REQ-017 SHALL grant d_gnt=1 whenever d_req=1 and p_req=0.
REQ-018 SHALL drive m_addr/m_wdata/m_wen from granted requester; with no grant m_wen=4'b0000, m_addr/m_wdata hold last driven values.
REQ-019 SHALL gate write enables: ungranted requester's wen never reaches m_wen.
REQ-020 SHALL treat a granted request with wen==4'b0000 as a read; record owner in rd_owner register (NONE/P/D).
REQ-021 SHALL assert p_rvalid (or d_rvalid) exactly one cycle after the granted read, for one cycle; granted writes produce no rvalid.
REQ-022 SHALL route m_rdata to p_rdata and d_rdata unconditionally; consumers qualify with rvalid.
REQ-023 SHALL support back-to-back reads from alternating owners with one rvalid per cycle, order preserved.
REQ-024 SHALL NOT stall p_req if d_req deasserts in the same cycle the forced grant would occur; pipeline granted.

Reset
REQ-025 SHALL on rst=1 asynchronously clear starve_cnt=0, rd_owner=NONE, p_rvalid=0, d_rvalid=0, m_addr/m_wdata hold regs=0.
REQ-026 SHALL drive m_wen=0, p_gnt=0, d_gnt=0, p_stall=0 while rst=1; requests during reset ignored.
REQ-027 SHALL drop any in-flight read on reset mid-operation: no rvalid in cycle after rst deasserts.

Verification
REQ-028 SHALL verify: p_req=1 read addr 0x100, d_req=0 -> p_gnt=1, m_wen=0, next cycle p_rvalid=1, p_rdata=mem[0x100].
REQ-029 SHALL verify: p_req and d_req held 1, STARVE_LIMIT=4 -> cycles 0-3 p_gnt=1; cycle 4 d_gnt=1, p_stall=1; cycle 5 starve_cnt=0, p_gnt=1.
REQ-030 SHALL verify: d_req write addr 0x40 data 0xDEADBEEF wen 4'b1111, p_req=0 -> d_gnt=1, m_wen=4'b1111; no d_rvalid; later p read 0x40 returns 0xDEADBEEF.
REQ-031 SHALL verify: p_req write wen 4'b0011 ungranted during forced debug read -> m_wen=0, memory unchanged, p_stall=1.
REQ-032 SHALL verify: alternating granted reads P,D,P on consecutive cycles -> p_rvalid, d_rvalid, p_rvalid in consecutive following cycles.
REQ-033 SHALL verify: rst pulsed 1 while read granted -> cycle after rst release p_rvalid=0, d_rvalid=0, starve_cnt=0.
